video_muldiv_arb: RTL and testbench

VIDEO_MULDIV_ARB -- requirements
Module: video_muldiv_arb

---
 rtl/video_muldiv_arb.sv | 169 ++++++++++++++++
 tb/tb_video_muldiv_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_muldiv_arb.sv
// video_muldiv_arb
//   Two-requester arbiter in front of one shared multiply/divide engine.
//   A request is granted in IDLE, issued to the engine in ISSUE, waited on in
//   WAIT and returned to its requester in RESP. Divide by zero bypasses the
//   engine and returns all ones.
//
// Ports
//   CLK_VIDEO          clock, rising edge
//   RESET_N            asynchronous active-low reset
//   REQ_VALID[1:0]     per-requester request, held until granted
//   REQ_OP[1:0]        per-requester op (0 multiply, 1 divide)
//   REQ_A0/REQ_A1      operand A (AW bits); multiplicand is A[BW-1:0]
//   REQ_B0/REQ_B1      operand B (BW bits)
//   REQ_READY[1:0]     one-cycle one-hot grant
//   RSP_VALID[1:0]     one-cycle one-hot result strobe
//   RSP_RES            result, held between strobes
//   ENG_START/ENG_OP/ENG_A/ENG_B   engine command
//   ENG_RUN/ENG_RES    engine busy flag and result
//   BUSY               high whenever the FSM is not in IDLE
//
// Build option
//   MULDIV_ARB_RR_EN   defined: round-robin arbitration
//                      undefined: fixed priority, requester 0 first
module video_muldiv_arb #(
    parameter int AW = 24,
    parameter int BW = 12
) (
    input  logic          CLK_VIDEO,
    input  logic          RESET_N,
    input  logic [1:0]    REQ_VALID,
    input  logic [1:0]    REQ_OP,
    input  logic [AW-1:0] REQ_A0,
    input  logic [AW-1:0] REQ_A1,
    input  logic [BW-1:0] REQ_B0,
    input  logic [BW-1:0] REQ_B1,
    output logic [1:0]    REQ_READY,
    output logic [1:0]    RSP_VALID,
    output logic [AW-1:0] RSP_RES,
    output logic          ENG_START,
    output logic          ENG_OP,
    output logic [AW-1:0] ENG_A,
    output logic [BW-1:0] ENG_B,
    input  logic          ENG_RUN,
    input  logic [AW-1:0] ENG_RES,
    output logic          BUSY
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_d;
    logic          win, win_d;
    logic          div0, div0_d;
    logic          pick;
    logic [1:0]    ready_d, rsp_valid_d;
    logic [AW-1:0] rsp_res_d, eng_a_d;
    logic [BW-1:0] eng_b_d;
    logic          eng_start_d, eng_op_d, busy_d;
    logic          sel_op;
    logic [AW-1:0] sel_a;
    logic [BW-1:0] sel_b;

`ifdef MULDIV_ARB_RR_EN
    logic rr_ptr, rr_ptr_d;

    // Pointer only matters when both requesters are asking at once.
    always_comb begin
        if (REQ_VALID[0] && REQ_VALID[1]) pick = rr_ptr;
        else                              pick = ~REQ_VALID[0];
    end
`else
    always_comb pick = ~REQ_VALID[0];
`endif

    always_comb begin
        sel_op = pick ? REQ_OP[1] : REQ_OP[0];
        sel_a  = pick ? REQ_A1    : REQ_A0;
        sel_b  = pick ? REQ_B1    : REQ_B0;
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state;
        win_d       = win;
        div0_d      = div0;
        ready_d     = '0;
        rsp_valid_d = '0;
        eng_start_d = 1'b0;
        rsp_res_d   = RSP_RES;
        eng_op_d    = ENG_OP;
        eng_a_d     = ENG_A;
        eng_b_d     = ENG_B;
`ifdef MULDIV_ARB_RR_EN
        rr_ptr_d    = rr_ptr;
`endif
        case (state)
            IDLE: begin
                // Never grant while the engine is still running, so a run
                // orphaned by a reset drains before the next job.
                if ((|REQ_VALID) && !ENG_RUN) begin
                    state_d     = ISSUE;
                    win_d       = pick;
                    eng_op_d    = sel_op;
                    eng_a_d     = sel_a;
                    eng_b_d     = sel_b;
                    div0_d      = sel_op && (sel_b == '0);
                    ready_d     = pick ? 2'b10 : 2'b01;
                    eng_start_d = !(sel_op && (sel_b == '0));
`ifdef MULDIV_ARB_RR_EN
                    rr_ptr_d    = ~pick;
`endif
                end
            end
            ISSUE: begin
                if (div0) begin
                    state_d     = RESP;
                    rsp_valid_d = win ? 2'b10 : 2'b01;
                    rsp_res_d   = '1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!ENG_START && !ENG_RUN) begin
                    state_d     = RESP;
                    rsp_valid_d = win ? 2'b10 : 2'b01;
                    rsp_res_d   = ENG_RES;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            win       <= 1'b0;
            div0      <= 1'b0;
            REQ_READY <= '0;
            RSP_VALID <= '0;
            RSP_RES   <= '0;
            ENG_START <= 1'b0;
            ENG_OP    <= 1'b0;
            ENG_A     <= '0;
            ENG_B     <= '0;
            BUSY      <= 1'b0;
`ifdef MULDIV_ARB_RR_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            win       <= win_d;
            div0      <= div0_d;
            REQ_READY <= ready_d;
            RSP_VALID <= rsp_valid_d;
            RSP_RES   <= rsp_res_d;
            ENG_START <= eng_start_d;
            ENG_OP    <= eng_op_d;
            ENG_A     <= eng_a_d;
            ENG_B     <= eng_b_d;
            BUSY      <= busy_d;
`ifdef MULDIV_ARB_RR_EN
            rr_ptr    <= rr_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_video_muldiv_arb.sv
module tb_video_muldiv_arb;
    localparam int AW = 24;
    localparam int BW = 12;

    logic          CLK_VIDEO = 1'b0;
    logic          RESET_N   = 1'b1;
    logic [1:0]    REQ_VALID = '0;
    logic [1:0]    REQ_OP    = '0;
    logic [AW-1:0] REQ_A0 = '0, REQ_A1 = '0;
    logic [BW-1:0] REQ_B0 = '0, REQ_B1 = '0;
    logic [1:0]    REQ_READY, RSP_VALID;
    logic [AW-1:0] RSP_RES;
    logic          ENG_START, ENG_OP;
    logic [AW-1:0] ENG_A;
    logic [BW-1:0] ENG_B;
    logic          ENG_RUN = 1'b0;
    logic [AW-1:0] ENG_RES = '0;
    logic          BUSY;

    int n_checks = 0;
    int n_pass   = 0;

    video_muldiv_arb #(.AW(AW), .BW(BW)) dut (
        .CLK_VIDEO(CLK_VIDEO), .RESET_N(RESET_N),
        .REQ_VALID(REQ_VALID), .REQ_OP(REQ_OP),
        .REQ_A0(REQ_A0), .REQ_A1(REQ_A1), .REQ_B0(REQ_B0), .REQ_B1(REQ_B1),
        .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_RES(RSP_RES),
        .ENG_START(ENG_START), .ENG_OP(ENG_OP), .ENG_A(ENG_A), .ENG_B(ENG_B),
        .ENG_RUN(ENG_RUN), .ENG_RES(ENG_RES), .BUSY(BUSY)
    );

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    // Reference arithmetic: multiply uses the low BW bits of A, result
    // truncated to AW; divide truncates, and divide by zero gives all ones.
    function automatic logic [AW-1:0] ref_res(input logic op, input logic [AW-1:0] a,
                                              input logic [BW-1:0] b);
        longint unsigned p;
        if (!op) begin
            p = (longint'(a) % (64'd1 << BW)) * longint'(b);
            return p[AW-1:0];
        end
        if (b == 0) return {AW{1'b1}};
        return a / AW'(b);
    endfunction

    // External engine model: ENG_RUN rises the cycle after ENG_START, stays
    // high eng_delay cycles, result presented as it falls; garbage meanwhile.
    int            eng_delay = 4;
    int            eng_cnt   = 0;
    logic          e_st, e_op;
    logic [AW-1:0] e_a, e_hold;
    logic [BW-1:0] e_b;
    always begin
        @(posedge CLK_VIDEO);
        e_st = ENG_START; e_op = ENG_OP; e_a = ENG_A; e_b = ENG_B;
        #1;
        if (e_st) begin
            eng_cnt = eng_delay;
            ENG_RUN = 1'b1;
            e_hold  = ref_res(e_op, e_a, e_b);
            ENG_RES = AW'($urandom);
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                ENG_RUN = 1'b0;
                ENG_RES = e_hold;
            end else begin
                ENG_RES = AW'($urandom);
            end
        end
    end

    task automatic set_req(input int i, input logic op, input logic [AW-1:0] a,
                           input logic [BW-1:0] b);
        if (i == 0) begin
            REQ_OP[0] = op; REQ_A0 = a; REQ_B0 = b; REQ_VALID[0] = 1'b1;
        end else begin
            REQ_OP[1] = op; REQ_A1 = a; REQ_B1 = b; REQ_VALID[1] = 1'b1;
        end
    endtask

    // Drives one job and records what the DUT did; cycle 1 is the cycle in
    // which the request is first presented.
    task automatic run_single(input int i, input logic op, input logic [AW-1:0] a,
                              input logic [BW-1:0] b, input int delay,
                              output logic [AW-1:0] res, output logic [AW-1:0] res_hold,
                              output int lat, output int nready, output int nstart,
                              output int nrsp, output logic [1:0] ready_who,
                              output logic [1:0] who, output bit stable);
        int cyc;
        eng_delay = delay;
        res = '0; res_hold = '0; lat = 0; nready = 0; nstart = 0; nrsp = 0;
        ready_who = '0; who = '0; stable = 1'b1; cyc = 1;
        set_req(i, op, a, b);
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK_VIDEO);
            cyc++;
            if (REQ_READY != 0) begin
                nready++; ready_who = REQ_READY; REQ_VALID[i] = 1'b0;
            end
            if (ENG_START) nstart++;
            if (BUSY && nready > 0 && (ENG_A !== a || ENG_B !== b || ENG_OP !== op))
                stable = 1'b0;
            if (lat != 0 && cyc == lat + 1) res_hold = RSP_RES;
            if (RSP_VALID != 0) begin
                nrsp++; who = RSP_VALID; res = RSP_RES;
                if (lat == 0) lat = cyc;
            end
            if (lat != 0 && cyc >= lat + 2) break;
        end
        REQ_VALID = '0;
    endtask

    task automatic check_job(input string nm, input int i, input logic op,
                             input logic [AW-1:0] a, input logic [BW-1:0] b, input int delay);
        logic [AW-1:0] res, hold, exp;
        int lat, nrd, nst, nrs, exp_lat;
        logic [1:0] rw, who, exp_who;
        bit stable, d0;
        d0      = op && (b == 0);
        exp     = ref_res(op, a, b);
        exp_lat = d0 ? 3 : delay + 4;
        exp_who = (i == 0) ? 2'b01 : 2'b10;
        run_single(i, op, a, b, delay, res, hold, lat, nrd, nst, nrs, rw, who, stable);
        n_checks++; if (res !== exp) $display("FAIL %s result got=%h exp=%h", nm, res, exp); else n_pass++;
        n_checks++; if (lat !== exp_lat) $display("FAIL %s latency got=%0d exp=%0d", nm, lat, exp_lat); else n_pass++;
        n_checks++; if (nrd !== 1 || rw !== exp_who) $display("FAIL %s grant got=%0d/%b exp=1/%b", nm, nrd, rw, exp_who); else n_pass++;
        n_checks++; if (nst !== (d0 ? 0 : 1)) $display("FAIL %s eng_start got=%0d exp=%0d", nm, nst, d0 ? 0 : 1); else n_pass++;
        n_checks++; if (nrs !== 1 || who !== exp_who) $display("FAIL %s rsp_valid got=%0d/%b exp=1/%b", nm, nrs, who, exp_who); else n_pass++;
        n_checks++; if (!stable) $display("FAIL %s operand_stability got=0 exp=1", nm); else n_pass++;
        n_checks++; if (hold !== exp) $display("FAIL %s rsp_hold got=%h exp=%h", nm, hold, exp); else n_pass++;
    endtask

    task automatic check_all_zero(input string nm);
        n_checks++; if (REQ_READY !== 2'b00) $display("FAIL %s req_ready got=%b exp=00", nm, REQ_READY); else n_pass++;
        n_checks++; if (RSP_VALID !== 2'b00) $display("FAIL %s rsp_valid got=%b exp=00", nm, RSP_VALID); else n_pass++;
        n_checks++; if (ENG_START !== 1'b0) $display("FAIL %s eng_start got=%b exp=0", nm, ENG_START); else n_pass++;
        n_checks++; if (ENG_OP !== 1'b0) $display("FAIL %s eng_op got=%b exp=0", nm, ENG_OP); else n_pass++;
        n_checks++; if (ENG_A !== '0) $display("FAIL %s eng_a got=%h exp=0", nm, ENG_A); else n_pass++;
        n_checks++; if (ENG_B !== '0) $display("FAIL %s eng_b got=%h exp=0", nm, ENG_B); else n_pass++;
        n_checks++; if (RSP_RES !== '0) $display("FAIL %s rsp_res got=%h exp=0", nm, RSP_RES); else n_pass++;
        n_checks++; if (BUSY !== 1'b0) $display("FAIL %s busy got=%b exp=0", nm, BUSY); else n_pass++;
    endtask

    task automatic test_reset;
        #2 RESET_N = 1'b0;
        #1 check_all_zero("reset");
        @(negedge CLK_VIDEO); @(negedge CLK_VIDEO);
        RESET_N = 1'b1;
        @(negedge CLK_VIDEO);
    endtask

    task automatic test_multiply;
        check_job("mul", 0, 1'b0, 24'h000123, 12'h010, 12);
        n_checks++; if (RSP_RES !== 24'h001230) $display("FAIL mul_literal got=%h exp=001230", RSP_RES); else n_pass++;
    endtask

    task automatic test_divide;
        check_job("div", 1, 1'b1, 24'h000438, 12'h0F0, 5);
        n_checks++; if (RSP_RES !== 24'h000004) $display("FAIL div_literal got=%h exp=000004", RSP_RES); else n_pass++;
    endtask

    task automatic test_div_zero;
        check_job("div0", 0, 1'b1, 24'h000005, 12'h000, 7);
        n_checks++; if (RSP_RES !== 24'hFFFFFF) $display("FAIL div0_literal got=%h exp=FFFFFF", RSP_RES); else n_pass++;
    endtask

    task automatic test_engine_handshake;
        check_job("eng_run1",  0, 1'b0, AW'($urandom), BW'($urandom_range(1, 4095)), 1);
        check_job("eng_run40", 1, 1'b1, AW'($urandom), BW'($urandom_range(1, 4095)), 40);
    endtask

    task automatic test_random;
        for (int n = 0; n < 10; n++) begin
            logic op;
            logic [BW-1:0] b;
            op = 1'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? '0 : BW'($urandom_range(1, 4095));
            check_job("random", int'($urandom_range(0, 1)), op, AW'($urandom), b,
                      int'($urandom_range(1, 8)));
        end
    endtask

    task automatic test_contention;
        logic          jop [2][4];
        logic [AW-1:0] ja  [2][4];
        logic [BW-1:0] jb  [2][4];
        int exp_order[$], got_order[$], got_who[$];
        logic [AW-1:0] exp_res[$], got_res[$];
        int pend[2], idx[2], ptr, w, g;
        @(negedge CLK_VIDEO) RESET_N = 1'b0;
        @(negedge CLK_VIDEO) RESET_N = 1'b1;
        eng_delay = int'($urandom_range(1, 6));
        for (int r = 0; r < 2; r++)
            for (int j = 0; j < 4; j++) begin
                jop[r][j] = 1'($urandom);
                ja[r][j]  = AW'($urandom);
                jb[r][j]  = BW'($urandom_range(1, 4095));
            end
        pend[0] = 4; pend[1] = 4; idx[0] = 0; idx[1] = 0; ptr = 0;
        for (int k = 0; k < 8; k++) begin
            if (pend[0] > 0 && pend[1] > 0) begin
`ifdef MULDIV_ARB_RR_EN
                w = ptr;
`else
                w = 0;
`endif
            end else begin
                w = (pend[0] > 0) ? 0 : 1;
            end
            ptr = 1 - w;
            exp_order.push_back(w);
            exp_res.push_back(ref_res(jop[w][idx[w]], ja[w][idx[w]], jb[w][idx[w]]));
            idx[w]++; pend[w]--;
        end
        idx[0] = 0; idx[1] = 0;
        set_req(0, jop[0][0], ja[0][0], jb[0][0]);
        set_req(1, jop[1][0], ja[1][0], jb[1][0]);
        for (int k = 0; k < 2000 && got_res.size() < 8; k++) begin
            @(negedge CLK_VIDEO);
            if (REQ_READY != 0) begin
                g = REQ_READY[1] ? 1 : 0;
                got_order.push_back(g);
                idx[g]++;
                if (idx[g] < 4) set_req(g, jop[g][idx[g]], ja[g][idx[g]], jb[g][idx[g]]);
                else REQ_VALID[g] = 1'b0;
            end
            if (RSP_VALID != 0) begin
                got_who.push_back(RSP_VALID[1] ? 1 : 0);
                got_res.push_back(RSP_RES);
            end
        end
        REQ_VALID = '0;
        n_checks++; if (got_res.size() != 8) $display("FAIL contention_count got=%0d exp=8", got_res.size()); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            if (k < got_order.size()) begin
                n_checks++; if (got_order[k] != exp_order[k]) $display("FAIL contention_grant[%0d] got=%0d exp=%0d", k, got_order[k], exp_order[k]); else n_pass++;
            end
            if (k < got_res.size()) begin
                n_checks++; if (got_who[k] != exp_order[k]) $display("FAIL contention_rsp[%0d] got=%0d exp=%0d", k, got_who[k], exp_order[k]); else n_pass++;
                n_checks++; if (got_res[k] !== exp_res[k]) $display("FAIL contention_res[%0d] got=%h exp=%h", k, got_res[k], exp_res[k]); else n_pass++;
            end
        end
        @(negedge CLK_VIDEO);
    endtask

    task automatic test_reset_mid_wait;
        int runs, early, bad0, granted, got;
        logic prev_run;
        logic [AW-1:0] res, exp;
        logic [AW-1:0] a1;
        logic [BW-1:0] b1;
        runs = 0; early = 0; bad0 = 0; granted = 0; got = 0; res = '0;
        eng_delay = 30;
        set_req(0, 1'b1, AW'($urandom), BW'($urandom_range(1, 4095)));
        for (int k = 0; k < 100 && runs < 3; k++) begin
            @(negedge CLK_VIDEO);
            if (REQ_READY != 0) REQ_VALID[0] = 1'b0;
            if (ENG_RUN) runs++;
        end
        n_checks++; if (runs != 3) $display("FAIL rst_wait_engine_started got=%0d exp=3", runs); else n_pass++;
        a1 = AW'($urandom); b1 = BW'($urandom_range(1, 4095));
        exp = ref_res(1'b0, a1, b1);
        REQ_VALID = '0;
        set_req(1, 1'b0, a1, b1);
        RESET_N = 1'b0;
        #1 check_all_zero("rst_wait");
        @(negedge CLK_VIDEO);
        RESET_N = 1'b1;
        prev_run = ENG_RUN;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK_VIDEO);
            if (REQ_READY != 0 && prev_run) early++;
            if (RSP_VALID[0]) bad0++;
            if (REQ_READY[1]) begin granted++; REQ_VALID[1] = 1'b0; end
            if (RSP_VALID[1]) begin got++; res = RSP_RES; end
            prev_run = ENG_RUN;
            if (got > 0 && !BUSY) break;
        end
        REQ_VALID = '0;
        n_checks++; if (early != 0) $display("FAIL rst_grant_while_run got=%0d exp=0", early); else n_pass++;
        n_checks++; if (bad0 != 0) $display("FAIL rst_orphan_rsp got=%0d exp=0", bad0); else n_pass++;
        n_checks++; if (granted != 1) $display("FAIL rst_next_grant got=%0d exp=1", granted); else n_pass++;
        n_checks++; if (got != 1) $display("FAIL rst_next_rsp got=%0d exp=1", got); else n_pass++;
        n_checks++; if (res !== exp) $display("FAIL rst_next_res got=%h exp=%h", res, exp); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_zero();
        test_engine_handshake();
        test_random();
        test_contention();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
